cpu_step_ctrl: RTL and testbench
================================

CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

Interface
REQ-001 Parameter CNT_W, default 32, sets the width of the executed-cycle counter.
REQ-002 Parameter STEP_W, default 8, sets the width of the step-length input and the remaining-ticks counter.
REQ-003 Port clk, input, 1, the single system clock; all logic is clocked on its rising edge.
REQ-004 Port reset, input, 1, asynchronous active-low reset; 0 resets the block immediately, independent of clk.
REQ-005 Port clk_slow, input, 1, the divided clock from the clock divider stage, synchronous to clk.
REQ-006 Port run, input, 1, level; 1 requests free-running CPU execution.
REQ-007 Port step, input, 1, single-clk pulse; requests a burst of step_len CPU ticks.
REQ-008 Port step_len, input, STEP_W, the number of ticks per step burst; 0 is treated as 1.
REQ-009 Port halt_req, input, 1, single-clk pulse from the CPU halt logic; forces the HALTED state.
REQ-010 Port resume, input, 1, single-clk pulse; releases the HALTED state.
REQ-011 Port cnt_clr, input, 1, synchronous clear of cycle_cnt.
REQ-012 Port cpu_en, output, 1, registered one-clk enable per granted CPU tick.
REQ-013 Port state, output, 2, current FSM state: IDLE=00, RUN=01, STEP=10, HALTED=11.
REQ-014 Port cycle_cnt, output, CNT_W, count of cpu_en pulses issued.

Function
REQ-015 The block SHALL register clk_slow into slow_q every clk; tick = clk_slow & ~slow_q (combinational, one clk wide per clk_slow rising edge).
REQ-016 cpu_en SHALL be registered: cpu_en <= tick & (state==RUN | state==STEP) & ~halt_req, evaluated with the pre-transition state; latency is 1 clk after the tick cycle; pulse width is exactly 1 clk.
REQ-017 IDLE: run=1 -> RUN; else step=1 -> STEP, with remaining loaded to step_len (or 1 if step_len==0); otherwise stay in IDLE.
REQ-018 RUN: run=0 -> IDLE; a tick present in the same cycle as run falling SHALL NOT produce cpu_en.
REQ-019 STEP: each tick decrements remaining; the tick with remaining==1 produces cpu_en and moves to IDLE; run and step are ignored while in STEP.
REQ-020 HALTED: resume=1 -> IDLE; all other inputs except reset are ignored; cpu_en is held at 0.
REQ-021 halt_req=1 in IDLE, RUN or STEP -> HALTED on the next edge; halt_req has priority over run, step and tick, and remaining is cleared.
REQ-022 Simultaneous run=1 and step=1 in IDLE -> RUN; the step is discarded.
REQ-023 cycle_cnt SHALL increment by 1 on each clk where cpu_en=1 and wrap from 2^CNT_W-1 to 0.
REQ-024 cnt_clr=1 SHALL set cycle_cnt to 0 on the next edge; clear has priority over a simultaneous increment.
REQ-025 The block SHALL NOT gate or drive any clock; cpu_en is the only timing output.

Reset
REQ-026 While reset=0: state=IDLE, cpu_en=0, cycle_cnt=0, remaining=0, slow_q=0.
REQ-027 Reset assertion mid-RUN or mid-STEP SHALL abort immediately; any burst in progress is lost.
REQ-028 After reset deasserts, a clk_slow already high SHALL register a tick on the first clk edge (slow_q=0).

Verification
REQ-029 Reset, clk_slow period 4 clk, run=1 for 40 clk -> cpu_en pulses 1 clk wide, 4 clk apart, 10 pulses, cycle_cnt=10, state=01.
REQ-030 In IDLE, step pulse with step_len=3 -> exactly 3 cpu_en pulses, then state=00, cycle_cnt +3; a second step sent during the burst is ignored.
REQ-031 step_len=0, step pulse -> exactly 1 cpu_en pulse, then IDLE.
REQ-032 In RUN, halt_req in the same cycle as tick -> no cpu_en for that tick, state=11; run held at 1 produces no pulses; resume -> state=00, then RUN on the next edge.
REQ-033 CNT_W=4, 17 ticks in RUN -> cycle_cnt wraps 15->0 and reads 1; cnt_clr asserted in the same cycle as cpu_en -> cycle_cnt=0.
REQ-034 reset driven low asynchronously mid-STEP (remaining=2) -> outputs reach reset values before the next clk edge; run and step both high after release -> RUN.

Source files
------------

// File: rtl/cpu_step_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_step_ctrl
//
// Run/step/halt controller for a CPU core that advances on a divided clock.
// It does not gate any clock. Each rising edge of clk_slow becomes a one-clk
// "tick", and the controller turns each tick it grants into a registered
// one-clk cpu_en pulse. It also counts how many cpu_en pulses it has issued.
//
// Ports
//   clk        : system clock; all logic updates on its rising edge
//   reset      : asynchronous active-low reset
//   clk_slow   : divided clock, synchronous to clk; its rising edges are ticks
//   run        : level; keeps the CPU free-running while high
//   step       : one-clk pulse; starts a burst of step_len ticks
//   step_len   : number of ticks in a step burst (0 behaves as 1)
//   halt_req   : one-clk pulse from the CPU halt logic; forces HALTED
//   resume     : one-clk pulse; leaves HALTED and returns to IDLE
//   cnt_clr    : synchronous clear of cycle_cnt
//   cpu_en     : registered one-clk enable for each granted tick
//   state      : IDLE=00, RUN=01, STEP=10, HALTED=11
//   cycle_cnt  : number of cpu_en pulses issued (wraps)
// -----------------------------------------------------------------------------
module cpu_step_ctrl #(
  parameter int CNT_W  = 32,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_slow,
  input  logic              run,
  input  logic              step,
  input  logic [STEP_W-1:0] step_len,
  input  logic              halt_req,
  input  logic              resume,
  input  logic              cnt_clr,
  output logic              cpu_en,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  cycle_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    STEP   = 2'b10,
    HALTED = 2'b11
  } state_t;

  state_t            cur_state;
  logic              slow_q;
  logic              tick;
  logic              grant;
  logic [STEP_W-1:0] remaining;
  logic [STEP_W-1:0] load_len;

  // Edge detector. slow_q resets to 0, so a clk_slow that is already high
  // when reset is released produces a tick on the first edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slow_q <= 1'b0;
    end else begin
      slow_q <= clk_slow;
    end
  end

  assign tick = clk_slow & ~slow_q;

  // A tick is granted only against the state held before this edge's
  // transition. In RUN, run must still be high, so a tick that arrives as run
  // falls is dropped. halt_req suppresses the tick in any state.
  assign grant = tick & ~halt_req &
                 (((cur_state == RUN) & run) | (cur_state == STEP));

  assign load_len = (step_len == '0) ? STEP_W'(1) : step_len;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= IDLE;
      remaining <= '0;
      cpu_en    <= 1'b0;
    end else begin
      cpu_en <= grant;
      if (halt_req && (cur_state != HALTED)) begin
        // halt_req wins over run, step and tick, and any unfinished burst is
        // discarded.
        cur_state <= HALTED;
        remaining <= '0;
      end else begin
        case (cur_state)
          IDLE: begin
            // When run and step arrive together, run wins and the step is
            // discarded.
            if (run) begin
              cur_state <= RUN;
            end else if (step) begin
              cur_state <= STEP;
              remaining <= load_len;
            end
          end
          RUN: begin
            if (!run) begin
              cur_state <= IDLE;
            end
          end
          STEP: begin
            // run and step are ignored here. The tick that consumes the last
            // remaining count is still granted, then the FSM returns to IDLE.
            if (tick) begin
              if (remaining <= STEP_W'(1)) begin
                remaining <= '0;
                cur_state <= IDLE;
              end else begin
                remaining <= remaining - STEP_W'(1);
              end
            end
          end
          HALTED: begin
            if (resume) begin
              cur_state <= IDLE;
            end
          end
          default: begin
            cur_state <= IDLE;
            remaining <= '0;
          end
        endcase
      end
    end
  end

  assign state = cur_state;

  // Count issued enables. A clear wins over an increment in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= '0;
    end else if (cnt_clr) begin
      cycle_cnt <= '0;
    end else if (cpu_en) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_step_ctrl
//
// Directed testbench for cpu_step_ctrl. It uses CNT_W=4 so that the counter
// wrap can be reached quickly. Inputs change on the falling edge of clk, and
// outputs are sampled on the falling edge or shortly after the rising edge.
// -----------------------------------------------------------------------------
module tb_cpu_step_ctrl;

  logic       clk;
  logic       reset;
  logic       clk_slow;
  logic       run;
  logic       step;
  logic [7:0] step_len;
  logic       halt_req;
  logic       resume;
  logic       cnt_clr;
  logic       cpu_en;
  logic [1:0] state;
  logic [3:0] cycle_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  // Pulse monitor. It is the only writer of these counters. Tasks take a
  // snapshot at their start and compare the difference.
  int en_count  = 0;
  int width_err = 0;
  int gap_err   = 0;
  int cyc_n     = 0;
  int last_cyc  = 0;
  bit have_last = 1'b0;
  bit prev_en   = 1'b0;
  int en_base;
  int wid_base;
  int gap_base;

  cpu_step_ctrl #(.CNT_W(4), .STEP_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_slow  (clk_slow),
    .run       (run),
    .step      (step),
    .step_len  (step_len),
    .halt_req  (halt_req),
    .resume    (resume),
    .cnt_clr   (cnt_clr),
    .cpu_en    (cpu_en),
    .state     (state),
    .cycle_cnt (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample 1 time unit after each rising edge. Count cpu_en pulses, flag
  // pulses wider than one clk, and flag spacings other than 4 clk.
  always @(posedge clk) begin
    #1;
    cyc_n++;
    if (cpu_en === 1'b1) begin
      en_count++;
      if (prev_en) width_err++;
      if (have_last && (cyc_n - last_cyc != 4)) gap_err++;
      have_last = 1'b1;
      last_cyc  = cyc_n;
    end
    prev_en = (cpu_en === 1'b1);
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic snap();
    en_base  = en_count;
    wid_base = width_err;
    gap_base = gap_err;
  endtask

  // Drive n clk_slow periods of 4 clk each, high for the first clk of each.
  task automatic slow_period(input int n);
    for (int i = 0; i < n; i++) begin
      clk_slow = 1'b1;
      @(negedge clk);
      clk_slow = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if (state !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_state: got %b expected 00", state); end
    tests_run++;
    if (cpu_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_cpu_en: got %b expected 0", cpu_en); end
    tests_run++;
    if (cycle_cnt !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_cnt: got %0d expected 0", cycle_cnt); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_run();
    snap();
    run = 1'b1;
    @(negedge clk);
    slow_period(10);
    tests_run++;
    if (en_count - en_base != 10) begin tests_failed++; $display("[TB] FAIL run_pulses: got %0d expected 10", en_count - en_base); end
    tests_run++;
    if (width_err - wid_base != 0) begin tests_failed++; $display("[TB] FAIL run_width: got %0d wide pulses expected 0", width_err - wid_base); end
    tests_run++;
    if (gap_err - gap_base != 0) begin tests_failed++; $display("[TB] FAIL run_spacing: got %0d bad gaps expected 0", gap_err - gap_base); end
    tests_run++;
    if (cycle_cnt !== 4'd10) begin tests_failed++; $display("[TB] FAIL run_cnt: got %0d expected 10", cycle_cnt); end
    tests_run++;
    if (state !== 2'b01) begin tests_failed++; $display("[TB] FAIL run_state: got %b expected 01", state); end
  endtask

  task automatic test_run_fall();
    snap();
    run      = 1'b0;
    clk_slow = 1'b1;
    @(negedge clk);
    clk_slow = 1'b0;
    @(negedge clk);
    tests_run++;
    if (en_count - en_base != 0) begin tests_failed++; $display("[TB] FAIL run_fall_pulse: got %0d expected 0", en_count - en_base); end
    tests_run++;
    if (state !== 2'b00) begin tests_failed++; $display("[TB] FAIL run_fall_state: got %b expected 00", state); end
    tests_run++;
    if (cycle_cnt !== 4'd10) begin tests_failed++; $display("[TB] FAIL run_fall_cnt: got %0d expected 10", cycle_cnt); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_step();
    snap();
    step_len = 8'd3;
    step     = 1'b1;
    @(negedge clk);
    step = 1'b0;
    slow_period(1);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    slow_period(3);
    tests_run++;
    if (en_count - en_base != 3) begin tests_failed++; $display("[TB] FAIL step3_pulses: got %0d expected 3", en_count - en_base); end
    tests_run++;
    if (state !== 2'b00) begin tests_failed++; $display("[TB] FAIL step3_state: got %b expected 00", state); end
    tests_run++;
    if (cycle_cnt !== 4'd13) begin tests_failed++; $display("[TB] FAIL step3_cnt: got %0d expected 13", cycle_cnt); end
  endtask

  task automatic test_step_zero();
    snap();
    step_len = 8'd0;
    step     = 1'b1;
    @(negedge clk);
    step = 1'b0;
    slow_period(3);
    tests_run++;
    if (en_count - en_base != 1) begin tests_failed++; $display("[TB] FAIL step0_pulses: got %0d expected 1", en_count - en_base); end
    tests_run++;
    if (state !== 2'b00) begin tests_failed++; $display("[TB] FAIL step0_state: got %b expected 00", state); end
    tests_run++;
    if (cycle_cnt !== 4'd14) begin tests_failed++; $display("[TB] FAIL step0_cnt: got %0d expected 14", cycle_cnt); end
  endtask

  task automatic test_halt_run();
    snap();
    run = 1'b1;
    @(negedge clk);
    clk_slow = 1'b1;
    halt_req = 1'b1;
    @(negedge clk);
    clk_slow = 1'b0;
    halt_req = 1'b0;
    tests_run++;
    if (state !== 2'b11) begin tests_failed++; $display("[TB] FAIL halt_state: got %b expected 11", state); end
    tests_run++;
    if (cpu_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL halt_tick_en: got %b expected 0", cpu_en); end
    slow_period(3);
    tests_run++;
    if (en_count - en_base != 0) begin tests_failed++; $display("[TB] FAIL halted_pulses: got %0d expected 0", en_count - en_base); end
    tests_run++;
    if (state !== 2'b11) begin tests_failed++; $display("[TB] FAIL halted_hold: got %b expected 11", state); end
    tests_run++;
    if (cycle_cnt !== 4'd14) begin tests_failed++; $display("[TB] FAIL halted_cnt: got %0d expected 14", cycle_cnt); end
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    tests_run++;
    if (state !== 2'b00) begin tests_failed++; $display("[TB] FAIL resume_state: got %b expected 00", state); end
    @(negedge clk);
    tests_run++;
    if (state !== 2'b01) begin tests_failed++; $display("[TB] FAIL resume_run: got %b expected 01", state); end
    run = 1'b0;
    @(negedge clk);
    tests_run++;
    if (state !== 2'b00) begin tests_failed++; $display("[TB] FAIL run_drop: got %b expected 00", state); end
  endtask

  task automatic test_halt_step();
    snap();
    step_len = 8'd5;
    step     = 1'b1;
    @(negedge clk);
    step = 1'b0;
    slow_period(1);
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    tests_run++;
    if (state !== 2'b11) begin tests_failed++; $display("[TB] FAIL halt_step_state: got %b expected 11", state); end
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    slow_period(2);
    tests_run++;
    if (state !== 2'b00) begin tests_failed++; $display("[TB] FAIL halt_step_idle: got %b expected 00", state); end
    tests_run++;
    if (en_count - en_base != 1) begin tests_failed++; $display("[TB] FAIL halt_step_pulses: got %0d expected 1", en_count - en_base); end
    tests_run++;
    if (cycle_cnt !== 4'd15) begin tests_failed++; $display("[TB] FAIL halt_step_cnt: got %0d expected 15", cycle_cnt); end
  endtask

  task automatic test_async_reset();
    step_len = 8'd3;
    step     = 1'b1;
    @(negedge clk);
    step     = 1'b0;
    clk_slow = 1'b1;
    @(posedge clk);
    #2;
    tests_run++;
    if (state !== 2'b10 || cpu_en !== 1'b1) begin tests_failed++; $display("[TB] FAIL pre_reset: got state %b en %b expected 10 1", state, cpu_en); end
    reset = 1'b0;
    #1;
    tests_run++;
    if (state !== 2'b00) begin tests_failed++; $display("[TB] FAIL async_state: got %b expected 00", state); end
    tests_run++;
    if (cpu_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL async_cpu_en: got %b expected 0", cpu_en); end
    tests_run++;
    if (cycle_cnt !== 4'd0) begin tests_failed++; $display("[TB] FAIL async_cnt: got %0d expected 0", cycle_cnt); end
    clk_slow = 1'b0;
    run      = 1'b1;
    step     = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (state !== 2'b01) begin tests_failed++; $display("[TB] FAIL run_step_prio: got %b expected 01", state); end
    run  = 1'b0;
    step = 1'b0;
    @(negedge clk);
    tests_run++;
    if (state !== 2'b00) begin tests_failed++; $display("[TB] FAIL post_reset_idle: got %b expected 00", state); end
  endtask

  task automatic test_wrap();
    snap();
    run = 1'b1;
    @(negedge clk);
    slow_period(17);
    tests_run++;
    if (en_count - en_base != 17) begin tests_failed++; $display("[TB] FAIL wrap_pulses: got %0d expected 17", en_count - en_base); end
    tests_run++;
    if (cycle_cnt !== 4'd1) begin tests_failed++; $display("[TB] FAIL wrap_cnt: got %0d expected 1", cycle_cnt); end
    clk_slow = 1'b1;
    @(negedge clk);
    clk_slow = 1'b0;
    cnt_clr  = 1'b1;
    tests_run++;
    if (cpu_en !== 1'b1) begin tests_failed++; $display("[TB] FAIL clr_en_present: got %b expected 1", cpu_en); end
    @(negedge clk);
    cnt_clr = 1'b0;
    tests_run++;
    if (cycle_cnt !== 4'd0) begin tests_failed++; $display("[TB] FAIL clr_priority: got %0d expected 0", cycle_cnt); end
    @(negedge clk);
    tests_run++;
    if (cycle_cnt !== 4'd0) begin tests_failed++; $display("[TB] FAIL clr_hold: got %0d expected 0", cycle_cnt); end
    run = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset    = 1'b0;
    clk_slow = 1'b0;
    run      = 1'b0;
    step     = 1'b0;
    step_len = 8'd0;
    halt_req = 1'b0;
    resume   = 1'b0;
    cnt_clr  = 1'b0;
    test_reset();
    test_run();
    test_run_fall();
    test_step();
    test_step_zero();
    test_halt_run();
    test_halt_step();
    test_async_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
